// File: rtl/exmem_wb_ctrl.sv
// exmem_wb_ctrl: Wishbone classic slave that makes the user-area block RAM
// behave like a slow external memory (DELAYS wait cycles per access).
module exmem_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
    parameter int          DELAYS    = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_di,
    output logic [31:0] bram_a,
    input  logic [31:0] bram_do
);
    typedef enum logic [1:0] {IDLE, S_WAIT, ACCESS, CAPT} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic [21:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic        hit, req;

    assign hit = wbs_adr_i[31:22] == BASE_ADDR[31:22];
    // The ack guard keeps the still-asserted strobe from starting a second access.
    assign req = wbs_cyc_i && wbs_stb_i && hit && !wbs_ack_o;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req ? ((DELAYS == 0) ? ACCESS : S_WAIT) : IDLE;
            S_WAIT:  state_n = !wbs_cyc_i ? IDLE : (cnt == 8'(DELAYS - 1)) ? ACCESS : S_WAIT;
            ACCESS:  state_n = CAPT;
            default: state_n = IDLE;
        endcase
    end

    assign bram_en = state == ACCESS;
    assign bram_we = (bram_en && we_q) ? sel_q : 4'b0;
    assign bram_di = dat_q;
    assign bram_a  = {10'b0, adr_q};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            cnt       <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
        end else begin
            state     <= state_n;
            wbs_ack_o <= (state == CAPT) && wbs_cyc_i;
            if (state == CAPT)
                wbs_dat_o <= we_q ? '0 : bram_do;
            if (state == IDLE && req) begin
                adr_q <= wbs_adr_i[21:0];
                dat_q <= wbs_dat_i;
                sel_q <= wbs_sel_i;
                we_q  <= wbs_we_i;
                cnt   <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule
